// File: rtl/fp_operand_issue_pkg.sv
// ---------------------------------------------------------------------------
// Module   : fp_operand_issue_pkg
// Brief    : Shared IEEE 754 single-precision field widths, class encoding
//            and constants for the FP add/sub issue stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fp_operand_issue_pkg;

    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;

    localparam logic [EXP_BITS-1:0] EXP_MAX    = 8'd255;
    localparam logic [31:0]         QNAN_CANON = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        SUBNORMAL = 3'd1,
        NORMAL    = 3'd2,
        INF       = 3'd3,
        QNAN      = 3'd4,
        SNAN      = 3'd5
    } fp_class_e;

    function automatic logic is_nan(input fp_class_e c);
        return (c == QNAN) || (c == SNAN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_operand_issue_if.sv
// ---------------------------------------------------------------------------
// Module   : fp_operand_issue_if
// Brief    : Upstream operand handshake and downstream issue bus of the
//            FP operand issue stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fp_operand_issue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    import fp_operand_issue_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   in_op;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_a;
    logic [WIDTH-1:0]       out_b;
    logic                   out_op;
    fp_class_e              out_class_a;
    fp_class_e              out_class_b;
    logic                   out_special;
    logic [WIDTH-1:0]       out_special_result;
    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op,
               out_class_a, out_class_b, out_special, out_special_result,
               fifo_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op,
               out_class_a, out_class_b, out_special, out_special_result,
               fifo_count
    );

endinterface

`default_nettype wire

// File: rtl/fp_operand_issue_classify.sv
// ---------------------------------------------------------------------------
// Module   : fp_classify
// Brief    : Combinational IEEE 754 single-precision operand classifier.
//            FP_DENORM_FLUSH_EN: subnormals become signed zero, class ZERO.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fp_classify
    import fp_operand_issue_pkg::*;
(
    input  wire logic [31:0] operand,
    output fp_class_e        op_class,
    output logic [31:0]      operand_out
);

    localparam int SIGN_BIT = EXP_BITS + MANT_BITS;

    logic [EXP_BITS-1:0]  w_exp;
    logic [MANT_BITS-1:0] w_mant;

    assign w_exp  = operand[SIGN_BIT-1:MANT_BITS];
    assign w_mant = operand[MANT_BITS-1:0];

    always_comb begin
        operand_out = operand;
        op_class    = NORMAL;
        if (w_exp == '0) begin
            if (w_mant == '0) begin
                op_class = ZERO;
            end else begin
`ifdef FP_DENORM_FLUSH_EN
                op_class    = ZERO;
                operand_out = {operand[SIGN_BIT], {SIGN_BIT{1'b0}}};
`else
                op_class    = SUBNORMAL;
`endif
            end
        end else if (w_exp == EXP_MAX) begin
            if (w_mant == '0)
                op_class = INF;
            else if (w_mant[MANT_BITS-1])
                op_class = QNAN;
            else
                op_class = SNAN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_operand_issue.sv
// ---------------------------------------------------------------------------
// Module   : fp_operand_issue
// Brief    : FIFO-buffered operand issue stage with IEEE 754 special-case
//            resolution; optional FP_DENORM_FLUSH_EN flushes subnormals.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fp_operand_issue
    import fp_operand_issue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fp_operand_issue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic             r_mem_op [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_out_op;
    fp_class_e        r_out_class_a;
    fp_class_e        r_out_class_b;
    logic             r_out_special;
    logic [WIDTH-1:0] r_out_special_result;

    logic w_in_ready, w_push_acc, w_load, w_fifo_empty, w_pop, w_bypass, w_fifo_push;

    assign w_in_ready   = (r_count < C_DEPTH);
    assign w_push_acc   = bus.in_valid && w_in_ready;
    assign w_load       = !r_out_valid || bus.out_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = w_load && !w_fifo_empty;
    // An empty FIFO lets a freshly accepted set go straight to the issue register.
    assign w_bypass     = w_load && w_fifo_empty && w_push_acc;
    assign w_fifo_push  = w_push_acc && !w_bypass;

    logic [WIDTH-1:0] w_src_a, w_src_b, w_a, w_b;
    logic             w_src_op;
    fp_class_e        w_class_a, w_class_b;

    assign w_src_a  = w_fifo_empty ? bus.in_a  : r_mem_a[r_rd_ptr];
    assign w_src_b  = w_fifo_empty ? bus.in_b  : r_mem_b[r_rd_ptr];
    assign w_src_op = w_fifo_empty ? bus.in_op : r_mem_op[r_rd_ptr];

    fp_classify u_class_a (.operand(w_src_a), .op_class(w_class_a), .operand_out(w_a));
    fp_classify u_class_b (.operand(w_src_b), .op_class(w_class_b), .operand_out(w_b));

    logic             w_eff_sign_b;
    logic             w_special;
    logic [WIDTH-1:0] w_special_result;

    assign w_eff_sign_b = w_b[WIDTH-1] ^ w_src_op;

    always_comb begin
        w_special        = 1'b1;
        w_special_result = QNAN_CANON;
        if (is_nan(w_class_a) || is_nan(w_class_b)) begin
            w_special_result = QNAN_CANON;
        end else if ((w_class_a == INF) && (w_class_b == INF) &&
                     (w_a[WIDTH-1] != w_eff_sign_b)) begin
            w_special_result = QNAN_CANON;
        end else if (w_class_a == INF) begin
            w_special_result = w_a;
        end else if (w_class_b == INF) begin
            w_special_result = {w_eff_sign_b, w_b[WIDTH-2:0]};
        end else if ((w_class_a == ZERO) && (w_class_b == ZERO)) begin
            w_special_result = {w_a[WIDTH-1] & w_eff_sign_b, {(WIDTH-1){1'b0}}};
        end else begin
            w_special        = 1'b0;
            w_special_result = '0;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_mem_a[r_wr_ptr]  <= bus.in_a;
            r_mem_b[r_wr_ptr]  <= bus.in_b;
            r_mem_op[r_wr_ptr] <= bus.in_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr             <= '0;
            r_rd_ptr             <= '0;
            r_count              <= '0;
            r_out_valid          <= 1'b0;
            r_out_a              <= '0;
            r_out_b              <= '0;
            r_out_op             <= 1'b0;
            r_out_class_a        <= ZERO;
            r_out_class_b        <= ZERO;
            r_out_special        <= 1'b0;
            r_out_special_result <= '0;
        end else begin
            if (w_fifo_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_fifo_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_valid <= w_pop || w_bypass;
                if (w_pop || w_bypass) begin
                    r_out_a              <= w_a;
                    r_out_b              <= w_b;
                    r_out_op             <= w_src_op;
                    r_out_class_a        <= w_class_a;
                    r_out_class_b        <= w_class_b;
                    r_out_special        <= w_special;
                    r_out_special_result <= w_special_result;
                end
            end
        end
    end

    assign bus.in_ready           = w_in_ready;
    assign bus.out_valid          = r_out_valid;
    assign bus.out_a              = r_out_a;
    assign bus.out_b              = r_out_b;
    assign bus.out_op             = r_out_op;
    assign bus.out_class_a        = r_out_class_a;
    assign bus.out_class_b        = r_out_class_b;
    assign bus.out_special        = r_out_special;
    assign bus.out_special_result = r_out_special_result;
    assign bus.fifo_count         = r_count;

endmodule

`default_nettype wire

// File: doc/fp_operand_issue.md
Name: fp_operand_issue

Overview:
- Upstream issue stage for the floating-point add/sub datapath.
- Accepts operand pairs (a, b, operation_select) over a valid/ready handshake and buffers them in a small FIFO.
- Classifies each operand and resolves IEEE 754 special cases (NaN, Inf, zero).
- Presents one registered operand set per cycle to the add_sub datapath, with a bypass result for special cases.

Parameters:
- WIDTH, 32, operand width; only 32 (single precision) is supported.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand set valid.
- in_ready  output  1  block can accept; equals (count < DEPTH).
- in_a  input  WIDTH  operand A, IEEE 754.
- in_b  input  WIDTH  operand B, IEEE 754.
- in_op  input  1  operation_select: 0 = add, 1 = subtract.
- out_valid  output  1  issue register holds a valid set.
- out_ready  input  1  datapath accepts the set.
- out_a  output  WIDTH  registered operand A.
- out_b  output  WIDTH  registered operand B.
- out_op  output  1  registered op.
- out_class_a  output  3  fp_class_e of A.
- out_class_b  output  3  fp_class_e of B.
- out_special  output  1  special case; out_special_result is final and the datapath result must be ignored.
- out_special_result  output  WIDTH  resolved special-case result.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count are 0.
  - out_valid=0 and all out_* data are 0; in_ready=1 after reset deasserts.
  - Reset mid-transfer discards all queued sets; there is no partial flush.
- Handshake:
  - Transfer occurs when valid && ready on a clock edge.
  - out_* are held stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on out_ready: at full, no push occurs in the same cycle as a pop.
- Issue register load condition: (!out_valid || out_ready).
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise the source is the accepted input directly (bypass), giving 1-cycle latency: accept at edge N, out_valid high after edge N.
  - Otherwise out_valid falls after the pop.
- FIFO:
  - Circular, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
  - Order is strictly preserved.
- Classification (on the load path, registered with the data):
  - exp=0, mant=0 -> ZERO.
  - exp=0, mant≠0 -> SUBNORMAL.
  - exp=255, mant=0 -> INF.
  - exp=255, mant[22]=1 -> QNAN.
  - exp=255, mant[22]=0, mant≠0 -> SNAN.
  - Otherwise NORMAL.
- Special resolution (effective sign of B = sign_b XOR op); first match wins:
  - Either operand NaN -> QNAN_CANON (0x7FC00000).
  - INF and INF with opposite effective signs -> QNAN_CANON.
  - Either operand INF -> that infinity, with effective sign applied for B.
  - Both ZERO -> +0, except -0 when sign_a and effective sign_b are both 1.
  - Otherwise out_special=0 and out_special_result=0.

Optional Feature:
- FP_DENORM_FLUSH_EN defined:
  - SUBNORMAL operands are replaced by a signed zero (sign kept) before registering.
  - Their class is reported as ZERO and participates in the zero rules.
- Undefined:
  - Subnormals pass unchanged with class SUBNORMAL, and out_special=0 for them.

Decomposition:
- global_params package gains:
  - fp_class_e enum (3-bit: ZERO, SUBNORMAL, NORMAL, INF, QNAN, SNAN).
  - QNAN_CANON constant.
  - EXP_MAX constant (255).
  - Reuse of the existing EXP_BITS and MANT_BITS.
- One combinational sub-module, fp_classify: input an operand, output class and flush-adjusted operand. Instantiated twice on the load path.
- Special resolution and the FIFO stay in fp_operand_issue.

Test Plan:
- Bypass latency:
  - Stimulus: empty, in_a=0x3F800000, in_b=0x40000000, op=0, out_ready=1.
  - Response: out_valid one cycle later with identical data, classes NORMAL/NORMAL, out_special=0.
- Back-pressure/full:
  - Stimulus: out_ready=0, push 5 sets.
  - Response: first set in the issue register, then 4 in the FIFO; fifo_count=4 and in_ready=0. Raising out_ready drains all sets in order, one per cycle.
- Inf cancel:
  - Stimulus: a=0x7F800000, b=0x7F800000, op=1.
  - Response: out_special=1, result 0x7FC00000. With op=0, result is 0x7F800000.
- NaN precedence:
  - Stimulus: a=0x7F800001 (SNAN), b=0xFF800000.
  - Response: class_a=SNAN, out_special=1, result 0x7FC00000.
- Zero signs:
  - Stimulus: a=0x80000000, b=0x00000000, op=1.
  - Response: result 0x80000000. With op=0, result is 0x00000000.
- Async reset and denormal:
  - Stimulus: assert rst mid-stream with fifo_count=3.
  - Response: outputs 0 immediately, before any clock edge.
  - Then push a=0x00000001: class SUBNORMAL without FP_DENORM_FLUSH_EN; with it, class ZERO and out_a=0x00000000.
